ternary_sampler_p: RTL and testbench
====================================

# ternary_sampler_p

Parametrised ternary sampler for the NTRU-HRSS encapsulation datapath. It consumes a stream of uniformly random bytes through a valid/ready handshake. Each byte is reduced modulo 3 into one ternary coefficient, and the block assembles a full `N_COEF`-coefficient polynomial (r or m) in a parallel output register. It sits between the random-bit source and the polynomial multiplier, and generalises the fixed 2-byte-per-clock sampler with the following additions:
- configurable lanes per beat
- explicit start/busy/done control
- flow control on the input
- a selectable output encoding

## Interface
Parameters:
- `N_COEF`, 1400: coefficients per sampled polynomial.
- `LANES`, 2: bytes (and therefore coefficients) accepted per beat. `N_COEF % LANES` must be 0; otherwise elaboration fails with `$error`.
- `ENC`, 0: coefficient encoding. 0 = unsigned residue {0,1,2}. 1 = signed 2-bit two's complement {0→00, 1→01, 2→11 (−1)}.

Ports:
- `local_clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: single-cycle pulse; clears the output and begins a new sampling run.
- `in_valid`, input, 1: random beat valid.
- `in_bits`, input, `8*LANES`: random bytes. Lane k = `in_bits[8k+7:8k]`.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `coeffs`, output, `2*N_COEF`: sampled polynomial. Coefficient i = `coeffs[2i+1:2i]`.
- `busy`, output, 1: run in progress.
- `done`, output, 1: polynomial complete and stable (level signal).

## Operation
- FSM states and transitions:
  - IDLE → FILL on `start`.
  - FILL → DONE when the final beat is accepted.
  - DONE → FILL on `start`.
  - FILL → FILL on `start` (restart).
- `start` behaviour: in any state, `start` clears `coeffs` to 0 and the beat counter to 0, and the next state is FILL.
- `in_ready = (state==FILL) & ~start`. A beat is accepted when `in_valid & in_ready`. A `start` in the same cycle as `in_valid` always wins, and the beat is not consumed.
- On acceptance:
  - Coefficients shift toward index 0 by `LANES` positions.
  - Lane k's reduced value is written to coefficient `N_COEF-LANES+k`.
  - After the run completes, coefficient i equals `(byte_i mod 3)`, where byte_i is the i-th byte of the accepted stream (lane 0 of beat 0 is byte 0).
- Beat counter: width `$clog2(N_COEF/LANES+1)`. It increments per accepted beat, and the run completes when the count reaches `N_COEF/LANES`. It never wraps.
- Reduction: exact `byte mod 3`, with a result of 0..2 for every input 0x00..0xFF. Encoding per `ENC` is applied before storage.
- In DONE, `coeffs` holds its value and `in_valid` is ignored until `start`.
- `busy = (state==FILL)`; `done = (state==DONE)`.

## Timing
- Reset values: state IDLE, `coeffs` all 0, `in_ready` 0, `busy` 0, `done` 0.
- Reset mid-run aborts immediately, with no partial result retained.
- `busy` rises the cycle after `start`. `in_ready` is high from that cycle, provided `start` is low.
- Throughput is one beat (`LANES` coefficients) per clock when `in_valid` is held high. A minimum run is `N_COEF/LANES` cycles of acceptance.
- `done` rises on the clock edge that accepts the final beat, so it is visible the following cycle. `coeffs` is final in that same cycle.
- Gaps in `in_valid` stall the run without loss. The counter and `coeffs` are unchanged on cycles with no acceptance.
- Outputs are registered, except `in_ready`, which is combinational from the state and `start`.

## Structure
- Shared package `ternary_pkg`:
  - encoding constants `ENC_UNSIGNED=0`, `ENC_SIGNED=1`
  - the 2-bit coefficient typedef `tcoef_t`
  - the encode function mapping a residue to `tcoef_t`
- Sub-module `byte_mod3`: combinational 8-bit → 2-bit exact mod-3 reducer, instantiated `LANES` times.
- The top level holds the FSM, beat counter and coefficient shift register.

## Test plan
Bench configuration is `N_COEF=8`, `LANES=2`, unless noted.
- Reset then idle: `coeffs=0`, `done=0`, `busy=0`, `in_ready=0`; beats presented with no `start` are not accepted.
- `start`, then beats {0x01,0x00}, {0x03,0x02}, {0xFF,0xFE}, {0x80,0x04}, continuous → `done` after the 4th acceptance; coeffs[0..7] = 0,1,2,0,2,0,1,2 (stream order byte0=0x00, byte1=0x01, …). With `ENC=1`, the coefficients equal to 2 read 2'b11.
- Same stream with `in_valid` low for 3 cycles between beats 2 and 3 → identical `coeffs`; `done` is delayed by 3 cycles.
- `start` asserted together with `in_valid` during beat 3 → that beat is not consumed, `coeffs` clears, and a new 4-beat run is required before `done`.
- `rst` pulsed mid-run → all outputs return to reset values; a subsequent `start` plus a full stream produces the correct polynomial.
- `N_COEF=1400`, `LANES=2`, exhaustive bytes 0x00..0xFF cycled → every coefficient equals the byte mod 3 against the reference model; `done` occurs exactly 700 accepted beats after `start`.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared types and helpers for the ternary sampling datapath.
// Defines the coefficient encodings, the 2-bit coefficient type and the FSM state type.
package ternary_pkg;

   localparam int unsigned ENC_UNSIGNED = 0;
   localparam int unsigned ENC_SIGNED   = 1;

   typedef logic [1:0] tcoef_t;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StDone
   } samp_state_t;

   // Residue 2 is -1 in the signed form, i.e. 2'b11.
   function automatic tcoef_t encode(input logic [1:0] res, input int unsigned enc);
      if (enc == ENC_UNSIGNED) return res;
      return (res == 2'd2) ? 2'b11 : res;
   endfunction

endpackage

// File: rtl/byte_mod3.sv
// Combinational exact byte mod 3.
// Since 4 == 1 (mod 3), the byte is folded as a sum of its 2-bit digits.
module byte_mod3 (
   input  logic [7:0] din,
   output logic [1:0] res
);

   logic [3:0] s1;
   logic [2:0] s2;
   logic [1:0] s3;

   always_comb begin
      s1 = 4'(din[1:0]) + 4'(din[3:2]) + 4'(din[5:4]) + 4'(din[7:6]);
      s2 = 3'(s1[3:2]) + 3'(s1[1:0]);
      // s2 <= 6, so this final fold never exceeds 3.
      s3 = 2'(s2[2]) + s2[1:0];
      res = (s3 == 2'd3) ? 2'd0 : s3;
   end

endmodule

// File: rtl/ternary_sampler_p.sv
// Ternary polynomial sampler: reduces random bytes mod 3 and shifts them into
// an N_COEF-coefficient register, LANES coefficients per accepted beat.
module ternary_sampler_p
   import ternary_pkg::*;
#(
   parameter int unsigned N_COEF = 1400,
   parameter int unsigned LANES  = 2,
   parameter int unsigned ENC    = 0
) (
   input  logic                  local_clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [8*LANES-1:0]    in_bits,
   output logic                  in_ready,
   output logic [2*N_COEF-1:0]   coeffs,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BEATS = N_COEF / LANES;
   localparam int unsigned CW    = $clog2(BEATS + 1);
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   if (N_COEF % LANES != 0) begin : g_bad_lanes
      $error("ternary_sampler_p: N_COEF must be a multiple of LANES");
   end
   if (ENC != ENC_UNSIGNED && ENC != ENC_SIGNED) begin : g_bad_enc
      $error("ternary_sampler_p: ENC must be 0 or 1");
   end

   samp_state_t            state;
   logic [CW-1:0]          cnt;
   tcoef_t [N_COEF-1:0]    coef_q;
   tcoef_t [N_COEF-1:0]    coef_shift;
   logic [1:0]             lane_res [LANES];
   tcoef_t [LANES-1:0]     lane_enc;
   logic                   accept;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      byte_mod3 u_mod3 (
         .din (in_bits[8*k +: 8]),
         .res (lane_res[k])
      );
   end

   assign in_ready = (state == StFill) & ~start;
   assign accept   = in_valid & in_ready;
   assign coeffs   = coef_q;

   // Oldest coefficients drift toward index 0; new lanes land at the top.
   always_comb begin
      coef_shift = coef_q;
      for (int k = 0; k < LANES; k++) begin
         lane_enc[k] = encode(lane_res[k], ENC);
      end
      for (int i = 0; i < N_COEF - LANES; i++) begin
         coef_shift[i] = coef_q[i + LANES];
      end
      for (int k = 0; k < LANES; k++) begin
         coef_shift[N_COEF - LANES + k] = lane_enc[k];
      end
   end

   always_ff @(posedge local_clk or posedge rst) begin
      if (rst) begin
         state  <= StIdle;
         cnt    <= '0;
         coef_q <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (start) begin
         state  <= StFill;
         cnt    <= '0;
         coef_q <= '0;
         busy   <= 1'b1;
         done   <= 1'b0;
      end else begin
         unique case (state)
            StFill: begin
               if (accept) begin
                  coef_q <= coef_shift;
                  cnt    <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     state <= StDone;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_sampler_p.sv
// Scoreboard bench for ternary_sampler_p: small unsigned/signed instances plus a
// full-size 1400-coefficient instance driven with the cycled byte sequence.
module tb_ternary_sampler_p;

   logic          clk = 1'b0;
   logic          rst;
   logic          s8, v8;
   logic [15:0]   b8;
   logic          rdy8, busy8, done8, rdy8s, busy8s, done8s;
   logic [15:0]   c8, c8s;
   logic          sb, vb;
   logic [15:0]   bb;
   logic          rdyb, busyb, doneb;
   logic [2799:0] cb;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            t0;
   logic [7:0]    q8 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ternary_sampler_p #(.N_COEF(8), .LANES(2), .ENC(0)) dut8 (
      .local_clk (clk), .rst (rst), .start (s8), .in_valid (v8), .in_bits (b8),
      .in_ready (rdy8), .coeffs (c8), .busy (busy8), .done (done8)
   );

   ternary_sampler_p #(.N_COEF(8), .LANES(2), .ENC(1)) dut8s (
      .local_clk (clk), .rst (rst), .start (s8), .in_valid (v8), .in_bits (b8),
      .in_ready (rdy8s), .coeffs (c8s), .busy (busy8s), .done (done8s)
   );

   ternary_sampler_p #(.N_COEF(1400), .LANES(2), .ENC(0)) dutb (
      .local_clk (clk), .rst (rst), .start (sb), .in_valid (vb), .in_bits (bb),
      .in_ready (rdyb), .coeffs (cb), .busy (busyb), .done (doneb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] enc_signed(input logic [7:0] v);
      logic [1:0] r;
      r = 2'(v % 3);
      return (r == 2'd2) ? 2'b11 : r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input string tag);
      s8 = 1'b1;
      q8.delete();
      tick();
      s8 = 1'b0;
      t0 = cyc;
      #1;
      check({tag, "_busy"}, 32'(busy8), 1);
      check({tag, "_rdy"}, 32'(rdy8), 1);
      check({tag, "_done"}, 32'(done8), 0);
      check({tag, "_clr"}, 32'(c8), 0);
   endtask

   task automatic beat(input string tag, input logic [15:0] bits);
      v8 = 1'b1;
      b8 = bits;
      #1;
      check({tag, "_rdy"}, 32'(rdy8), 1);
      q8.push_back(bits[7:0]);
      q8.push_back(bits[15:8]);
      tick();
      v8 = 1'b0;
   endtask

   task automatic compare_run(input string tag);
      logic [7:0] v;
      check({tag, "_qsize"}, 32'(q8.size()), 8);
      for (int i = 0; i < 8; i++) begin
         if (q8.size() == 0) break;
         v = q8.pop_front();
         check($sformatf("%s_u%0d", tag, i), 32'(c8[2*i +: 2]), 32'(v % 3));
         check($sformatf("%s_s%0d", tag, i), 32'(c8s[2*i +: 2]), 32'(enc_signed(v)));
      end
   endtask

   task automatic main_stream(input string tag);
      beat({tag, "_b0"}, 16'h0100);
      beat({tag, "_b1"}, 16'h0302);
      beat({tag, "_b2"}, 16'hFFFE);
      check({tag, "_early"}, 32'(done8), 0);
      beat({tag, "_b3"}, 16'h8004);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s8 = 1'b0; v8 = 1'b0; b8 = '0; sb = 1'b0; vb = 1'b0; bb = '0;
      tick(); tick();
      check("rst_coeffs", 32'(c8), 0);
      check("rst_busy", 32'(busy8), 0);
      check("rst_done", 32'(done8), 0);
      check("rst_rdy", 32'(rdy8), 0);
      rst = 1'b0;

      // Beats without start must be ignored.
      v8 = 1'b1; b8 = 16'hFFFF;
      #1;
      check("idle_rdy", 32'(rdy8), 0);
      tick(); tick();
      v8 = 1'b0;
      check("idle_coeffs", 32'(c8), 0);
      check("idle_busy", 32'(busy8), 0);

      // Continuous run.
      do_start("run1");
      main_stream("run1");
      check("run1_done", 32'(done8), 1);
      check("run1_busy", 32'(busy8), 0);
      check("run1_lat", 32'(cyc - t0), 4);
      check("run1_poly_u", 32'(c8), 32'h0000_9224);
      check("run1_poly_s", 32'(c8s), 32'h0000_D334);
      compare_run("run1");

      // DONE holds and ignores input.
      v8 = 1'b1; b8 = 16'h1234;
      #1;
      check("hold_rdy", 32'(rdy8), 0);
      tick(); tick();
      v8 = 1'b0;
      check("hold_done", 32'(done8), 1);
      check("hold_poly", 32'(c8), 32'h0000_9224);

      // Gap of three idle cycles mid-run.
      do_start("gap");
      beat("gap_b0", 16'h0100);
      beat("gap_b1", 16'h0302);
      for (int g = 0; g < 3; g++) begin
         tick();
         check($sformatf("gap_stall%0d", g), 32'(c8), 32'h0000_2400);
         check($sformatf("gap_done%0d", g), 32'(done8), 0);
      end
      beat("gap_b2", 16'hFFFE);
      beat("gap_b3", 16'h8004);
      check("gap_done", 32'(done8), 1);
      check("gap_lat", 32'(cyc - t0), 7);
      compare_run("gap");

      // Start colliding with a valid beat restarts and drops the beat.
      do_start("col");
      beat("col_b0", 16'h0100);
      beat("col_b1", 16'h0302);
      s8 = 1'b1; v8 = 1'b1; b8 = 16'hFFFE;
      #1;
      check("col_rdy", 32'(rdy8), 0);
      q8.delete();
      tick();
      s8 = 1'b0; v8 = 1'b0;
      check("col_clr", 32'(c8), 0);
      check("col_busy", 32'(busy8), 1);
      check("col_done0", 32'(done8), 0);
      beat("col_b2", 16'h5A11);
      beat("col_b3", 16'h7733);
      beat("col_b4", 16'hC0DE);
      check("col_early", 32'(done8), 0);
      beat("col_b5", 16'h2B99);
      check("col_done", 32'(done8), 1);
      compare_run("col");

      // Asynchronous reset mid-run.
      do_start("rmid");
      beat("rmid_b0", 16'h0100);
      beat("rmid_b1", 16'h0302);
      #2 rst = 1'b1;
      #1;
      check("rmid_coeffs", 32'(c8), 0);
      check("rmid_coeffs_s", 32'(c8s), 0);
      check("rmid_busy", 32'(busy8), 0);
      check("rmid_done", 32'(done8), 0);
      check("rmid_rdy", 32'(rdy8), 0);
      tick();
      rst = 1'b0;
      do_start("rpost");
      main_stream("rpost");
      check("rpost_done", 32'(done8), 1);
      check("rpost_poly_u", 32'(c8), 32'h0000_9224);
      compare_run("rpost");

      // Full-size run over the cycled byte sequence.
      sb = 1'b1;
      tick();
      sb = 1'b0;
      t0 = cyc;
      for (int j = 0; j < 700; j++) begin
         vb = 1'b1;
         bb = {8'((2 * j + 1) % 256), 8'((2 * j) % 256)};
         #1;
         if (j == 0) check("big_rdy", 32'(rdyb), 1);
         if (j == 699) check("big_early", 32'(doneb), 0);
         tick();
         vb = 1'b0;
      end
      check("big_done", 32'(doneb), 1);
      check("big_lat", 32'(cyc - t0), 700);
      for (int i = 0; i < 1400; i++) begin
         check($sformatf("big_c%0d", i), 32'(cb[2*i +: 2]), 32'((i % 256) % 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
